// File: rtl/branch_unit_pkg.sv
// Shared types for the execute-stage branch unit: operation codes, FSM
// encodings and a small alignment helper.
package branch_unit_pkg;

   localparam int OP_WIDTH       = 4;
   localparam int BR_STATE_WIDTH = 1;

   typedef logic [31:0]         word_t;
   typedef logic [OP_WIDTH-1:0] oper_t;

   localparam oper_t OP_BEQ  = 4'd1;
   localparam oper_t OP_BNE  = 4'd2;
   localparam oper_t OP_BLT  = 4'd3;
   localparam oper_t OP_BGE  = 4'd4;
   localparam oper_t OP_BLTU = 4'd5;
   localparam oper_t OP_BGEU = 4'd6;

   typedef enum logic [BR_STATE_WIDTH-1:0] {
      BR_IDLE = 1'b0,
      BR_PEND = 1'b1
   } br_state_e;

   function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
      return (addr_lsb == 2'b00);
   endfunction

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator: decodes the B-type op and compares the operands.
module branch_cmp
   import branch_unit_pkg::*;
(
   input  oper_t op,
   input  word_t rs1,
   input  word_t rs2,
   output logic  is_branch,
   output logic  taken
);

   // Condition decode; unknown ops are treated as non-branches.
   always_comb begin
      is_branch = 1'b1;
      taken     = 1'b0;
      case (op)
         OP_BEQ:  taken = (rs1 == rs2);
         OP_BNE:  taken = (rs1 != rs2);
         OP_BLT:  taken = ($signed(rs1) <  $signed(rs2));
         OP_BGE:  taken = ($signed(rs1) >= $signed(rs2));
         OP_BLTU: taken = (rs1 <  rs2);
         OP_BGEU: taken = (rs1 >= rs2);
         default: begin
            is_branch = 1'b0;
            taken     = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/branch_unit.sv
// Execute-stage branch resolution with a registered redirect handshake to fetch.
// Optional dynamic-prediction support is enabled by defining BRANCH_PREDICT_EN.
module branch_unit
   import branch_unit_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  valid_i,
   input  oper_t op_i,
   input  word_t pc_i,
   input  word_t imm_i,
   input  word_t rs1_data_i,
   input  word_t rs2_data_i,
`ifdef BRANCH_PREDICT_EN
   input  logic  pred_taken_i,
`endif
   output logic  redirect_valid_o,
   output word_t redirect_pc_o,
   input  logic  redirect_ready_i,
   output logic  flush_o,
   output logic  misalign_o,
   output logic  stall_o
);

   br_state_e state_r;
   br_state_e state_next_s;
   logic      is_branch_s;
   logic      taken_s;
   logic      sample_s;
   logic      need_s;
   logic      aligned_s;
   logic      go_s;
   logic      misalign_s;
   word_t     target_s;
   word_t     chosen_s;
   logic      redirect_valid_r;
   word_t     redirect_pc_r;
   logic      flush_r;
   logic      misalign_r;

   branch_cmp u_cmp (
      .op        (op_i),
      .rs1       (rs1_data_i),
      .rs2       (rs2_data_i),
      .is_branch (is_branch_s),
      .taken     (taken_s)
   );

   // The immediate is in halfword units; the shift drops its top bit on purpose.
   assign target_s = pc_i + (imm_i << 5'd1);

`ifdef BRANCH_PREDICT_EN
   word_t fall_s;
   assign fall_s = pc_i + 32'd4;

   // Redirect only on misprediction, to whichever path was actually taken.
   always_comb begin
      need_s   = (taken_s != pred_taken_i);
      chosen_s = taken_s ? target_s : fall_s;
   end
`else
   // Static not-taken: every taken branch redirects to its target.
   always_comb begin
      need_s   = taken_s;
      chosen_s = target_s;
   end
`endif

   assign stall_o    = (state_r == BR_PEND);
   assign sample_s   = valid_i && !stall_o && is_branch_s;
   assign aligned_s  = is_word_aligned(chosen_s[1:0]);
   assign go_s       = sample_s && need_s && aligned_s;
   assign misalign_s = sample_s && need_s && !aligned_s;

   // Next-state: leave IDLE on an aligned redirect, leave PEND on acceptance.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         BR_IDLE: begin
            if (go_s) state_next_s = BR_PEND;
            else      state_next_s = BR_IDLE;
         end
         BR_PEND: begin
            if (redirect_ready_i) state_next_s = BR_IDLE;
            else                  state_next_s = BR_PEND;
         end
         default: state_next_s = BR_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= BR_IDLE;
      else        state_r <= state_next_s;
   end

   // Output registers; the redirect PC is held untouched while pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_valid_r <= 1'b0;
         redirect_pc_r    <= 32'd0;
         flush_r          <= 1'b0;
         misalign_r       <= 1'b0;
      end else begin
         redirect_valid_r <= (state_next_s == BR_PEND);
         flush_r          <= go_s;
         misalign_r       <= misalign_s;
         if (go_s) redirect_pc_r <= chosen_s;
         else      redirect_pc_r <= redirect_pc_r;
      end
   end

   assign redirect_valid_o = redirect_valid_r;
   assign redirect_pc_o    = redirect_pc_r;
   assign flush_o          = flush_r;
   assign misalign_o       = misalign_r;

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit (default and BRANCH_PREDICT_EN builds).
module tb_branch_unit;
   import branch_unit_pkg::*;

   logic  clk;
   logic  rst_n;
   logic  valid_i;
   oper_t op_i;
   word_t pc_i;
   word_t imm_i;
   word_t rs1_data_i;
   word_t rs2_data_i;
   logic  pred_taken_i;
   logic  redirect_valid_o;
   word_t redirect_pc_o;
   logic  redirect_ready_i;
   logic  flush_o;
   logic  misalign_o;
   logic  stall_o;

   int tests_run;
   int tests_failed;

   branch_unit dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .valid_i          (valid_i),
      .op_i             (op_i),
      .pc_i             (pc_i),
      .imm_i            (imm_i),
      .rs1_data_i       (rs1_data_i),
      .rs2_data_i       (rs2_data_i),
`ifdef BRANCH_PREDICT_EN
      .pred_taken_i     (pred_taken_i),
`endif
      .redirect_valid_o (redirect_valid_o),
      .redirect_pc_o    (redirect_pc_o),
      .redirect_ready_i (redirect_ready_i),
      .flush_o          (flush_o),
      .misalign_o       (misalign_o),
      .stall_o          (stall_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input oper_t op, input word_t pc, input word_t imm,
                        input word_t a, input word_t b);
      valid_i    = 1'b1;
      op_i       = op;
      pc_i       = pc;
      imm_i      = imm;
      rs1_data_i = a;
      rs2_data_i = b;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; valid_i = 1'b0; op_i = 4'd0; pc_i = 32'd0; imm_i = 32'd0;
      rs1_data_i = 32'd0; rs2_data_i = 32'd0; pred_taken_i = 1'b0; redirect_ready_i = 1'b1;
      tick(); tick();
      tests_run++; if (redirect_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b want 0", redirect_valid_o); end
      tests_run++; if (redirect_pc_o !== 32'd0) begin tests_failed++; $display("FAIL reset_pc: got %h want 0", redirect_pc_o); end
      tests_run++; if ({flush_o, misalign_o, stall_o} !== 3'b000) begin tests_failed++; $display("FAIL reset_pulses: got %b want 000", {flush_o, misalign_o, stall_o}); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_beq_taken();
      redirect_ready_i = 1'b1;
      drive(OP_BEQ, 32'h100, 32'h8, 32'd5, 32'd5);
      tick();
      valid_i = 1'b0;
      tests_run++; if ({redirect_valid_o, flush_o, stall_o} !== 3'b111) begin tests_failed++; $display("FAIL beq_flags: got %b want 111", {redirect_valid_o, flush_o, stall_o}); end
      tests_run++; if (redirect_pc_o !== 32'h110) begin tests_failed++; $display("FAIL beq_pc: got %h want 00000110", redirect_pc_o); end
      tick();
      tests_run++; if ({redirect_valid_o, flush_o, stall_o} !== 3'b000) begin tests_failed++; $display("FAIL beq_after: got %b want 000", {redirect_valid_o, flush_o, stall_o}); end
   endtask

   task automatic test_signed_unsigned();
      redirect_ready_i = 1'b1;
      drive(OP_BLT, 32'h400, 32'h10, 32'hFFFF_FFFF, 32'd1);
      tick();
      valid_i = 1'b0;
      tests_run++; if ({redirect_valid_o, redirect_pc_o} !== {1'b1, 32'h420}) begin tests_failed++; $display("FAIL blt_taken: got %b/%h want 1/00000420", redirect_valid_o, redirect_pc_o); end
      tick();
      drive(OP_BLTU, 32'h500, 32'h10, 32'hFFFF_FFFF, 32'd1);
      tick();
      valid_i = 1'b0;
      tests_run++; if ({redirect_valid_o, flush_o, stall_o} !== 3'b000) begin tests_failed++; $display("FAIL bltu_not_taken: got %b want 000", {redirect_valid_o, flush_o, stall_o}); end
      drive(OP_BGEU, 32'h600, 32'h20, 32'hFFFF_FFFF, 32'd1);
      tick();
      valid_i = 1'b0;
      tests_run++; if ({redirect_valid_o, redirect_pc_o} !== {1'b1, 32'h640}) begin tests_failed++; $display("FAIL bgeu_taken: got %b/%h want 1/00000640", redirect_valid_o, redirect_pc_o); end
      tick();
   endtask

   task automatic test_backpressure();
      redirect_ready_i = 1'b0;
      drive(OP_BNE, 32'h800, 32'h20, 32'd1, 32'd2);
      tick();
      drive(OP_BEQ, 32'h900, 32'h4, 32'd7, 32'd7);
      for (int c = 0; c < 3; c++) begin
         tests_run++; if ({redirect_valid_o, stall_o, redirect_pc_o} !== {2'b11, 32'h840}) begin tests_failed++; $display("FAIL bp_hold_%0d: got %b%b/%h want 11/00000840", c, redirect_valid_o, stall_o, redirect_pc_o); end
         tests_run++; if (flush_o !== (c == 0)) begin tests_failed++; $display("FAIL bp_flush_%0d: got %0b want %0b", c, flush_o, (c == 0)); end
         if (c == 2) redirect_ready_i = 1'b1;
         tick();
      end
      tests_run++; if ({redirect_valid_o, stall_o, flush_o} !== 3'b000) begin tests_failed++; $display("FAIL bp_accept: got %b want 000", {redirect_valid_o, stall_o, flush_o}); end
      tick();
      valid_i = 1'b0;
      tests_run++; if ({redirect_valid_o, flush_o, redirect_pc_o} !== {2'b11, 32'h908}) begin tests_failed++; $display("FAIL bp_second: got %b%b/%h want 11/00000908", redirect_valid_o, flush_o, redirect_pc_o); end
      tick();
   endtask

   task automatic test_back_to_back();
      redirect_ready_i = 1'b1;
      drive(OP_BGE, 32'hA00, 32'h8, 32'd3, 32'd3);
      tick();
      tests_run++; if ({redirect_valid_o, flush_o} !== 2'b11) begin tests_failed++; $display("FAIL b2b_first: got %b want 11", {redirect_valid_o, flush_o}); end
      tick();
      tests_run++; if ({redirect_valid_o, stall_o} !== 2'b00) begin tests_failed++; $display("FAIL b2b_gap: got %b want 00", {redirect_valid_o, stall_o}); end
      tick();
      valid_i = 1'b0;
      tests_run++; if ({redirect_valid_o, flush_o, redirect_pc_o} !== {2'b11, 32'hA10}) begin tests_failed++; $display("FAIL b2b_second: got %b%b/%h want 11/00000a10", redirect_valid_o, flush_o, redirect_pc_o); end
      tick();
   endtask

   task automatic test_wrap_misalign();
      redirect_ready_i = 1'b1;
      drive(OP_BEQ, 32'hFFFF_FFFC, 32'h4, 32'd0, 32'd0);
      tick();
      valid_i = 1'b0;
      tests_run++; if ({redirect_valid_o, redirect_pc_o} !== {1'b1, 32'h4}) begin tests_failed++; $display("FAIL wrap_pc: got %b/%h want 1/00000004", redirect_valid_o, redirect_pc_o); end
      tick();
      drive(OP_BEQ, 32'h100, 32'h1, 32'd9, 32'd9);
      tick();
      valid_i = 1'b0;
      tests_run++; if ({misalign_o, redirect_valid_o, flush_o, stall_o} !== 4'b1000) begin tests_failed++; $display("FAIL misalign: got %b want 1000", {misalign_o, redirect_valid_o, flush_o, stall_o}); end
      tick();
      tests_run++; if (misalign_o !== 1'b0) begin tests_failed++; $display("FAIL misalign_pulse: got %0b want 0", misalign_o); end
   endtask

   task automatic test_predict();
      redirect_ready_i = 1'b1;
      pred_taken_i = 1'b1;
      drive(OP_BGE, 32'h200, 32'h40, 32'd1, 32'd5);
      tick();
      valid_i = 1'b0;
`ifdef BRANCH_PREDICT_EN
      tests_run++; if ({redirect_valid_o, redirect_pc_o} !== {1'b1, 32'h204}) begin tests_failed++; $display("FAIL pred_mispredict: got %b/%h want 1/00000204", redirect_valid_o, redirect_pc_o); end
      tick();
      drive(OP_BEQ, 32'h300, 32'h8, 32'd4, 32'd4);
      tick();
      valid_i = 1'b0;
      tests_run++; if ({redirect_valid_o, flush_o} !== 2'b00) begin tests_failed++; $display("FAIL pred_correct: got %b want 00", {redirect_valid_o, flush_o}); end
`else
      tests_run++; if ({redirect_valid_o, flush_o, stall_o} !== 3'b000) begin tests_failed++; $display("FAIL static_not_taken: got %b want 000", {redirect_valid_o, flush_o, stall_o}); end
`endif
      pred_taken_i = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_pend();
      redirect_ready_i = 1'b0;
      drive(OP_BNE, 32'hC00, 32'h10, 32'd1, 32'd0);
      tick();
      valid_i = 1'b0;
      tests_run++; if (redirect_valid_o !== 1'b1) begin tests_failed++; $display("FAIL rst_pend_setup: got %0b want 1", redirect_valid_o); end
      #2 rst_n = 1'b0;
      #1;
      tests_run++; if ({redirect_valid_o, flush_o, misalign_o, stall_o, redirect_pc_o} !== 36'd0) begin tests_failed++; $display("FAIL rst_async: got %b%b%b%b/%h want 0000/00000000", redirect_valid_o, flush_o, misalign_o, stall_o, redirect_pc_o); end
      #2 rst_n = 1'b1;
      redirect_ready_i = 1'b1;
      tick();
      tests_run++; if ({redirect_valid_o, stall_o} !== 2'b00) begin tests_failed++; $display("FAIL rst_no_stale: got %b want 00", {redirect_valid_o, stall_o}); end
      drive(OP_BLTU, 32'hD00, 32'h2, 32'd1, 32'd2);
      tick();
      valid_i = 1'b0;
      tests_run++; if ({redirect_valid_o, flush_o, redirect_pc_o} !== {2'b11, 32'hD04}) begin tests_failed++; $display("FAIL rst_new_branch: got %b%b/%h want 11/00000d04", redirect_valid_o, flush_o, redirect_pc_o); end
      tick();
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_beq_taken();
      test_signed_unsigned();
      test_backpressure();
      test_back_to_back();
      test_wrap_misalign();
      test_predict();
      test_reset_mid_pend();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
